rr_arb_queue: RTL and testbench
===============================

// Module: rr_arb_queue
// PURPOSE
//  N-source payload collector in front of a shared consumer. Each source offers a W-bit payload
//  with valid/ready; a round-robin pick selects one source per cycle; the winner's payload and
//  source index enter a DEPTH-entry FIFO; the consumer drains the FIFO with valid/ready.
//  Arbitration pointer advances only on an accepted push, so fairness holds under back-pressure.
// PARAMETERS
//  N      4  number of request sources (>=2)
//  W      32 payload width in bits
//  DEPTH  4  FIFO entries (>=2, need not be a power of two)
// PORTS
//  clk_i       in   1               clock, all state on rising edge
//  rst_i       in   1               reset, asynchronous, active-high
//  req_vld_i   in   N               per-source payload valid
//  req_data_i  in   N*W             source k payload in bits [k*W +: W]
//  req_rdy_o   out  N               one-hot: source k's payload is accepted this cycle
//  out_vld_o   out  1               FIFO head valid
//  out_data_o  out  W               head payload
//  out_src_o   out  $clog2(N)       head source index
//  out_rdy_i   in   1               consumer accepts head
// BEHAVIOUR
//  - Reset: FIFO count, rd/wr pointers 0; arbiter pointer all-ones (source 0 highest priority);
//    out_vld_o=0, out_data_o=0, out_src_o=0, req_rdy_o=0.
//  - Arbitration: embedded round_robin_arbiter, req_i=req_vld_i, req_can_go_i=~full.
//    Priority after a grant to k: k+1..N-1 first, then 0..k (wrap-around).
//  - req_rdy_o = grant & {N{~full}}; push = |req_rdy_o; exactly one source accepted per push.
//  - full = (count==DEPTH), decided on registered count only: no push into a full FIFO even when
//    a pop occurs in the same cycle (no pass-through-full path).
//  - pop = out_vld_o & out_rdy_i. Push and pop in the same cycle: count unchanged, both pointers move.
//  - Pointers wrap DEPTH-1 -> 0 explicitly; count width $clog2(DEPTH+1).
//  - out_vld_o = (count!=0); out_data_o/out_src_o gated to 0 when out_vld_o=0.
//  - Latency: accepted payload appears at out_* the cycle after acceptance (empty FIFO).
//  - Sources must hold req_vld_i/req_data_i until req_rdy_o; dropping valid early is legal and
//    simply removes the source from arbitration (no payload captured).
//  - Storage array not reset; reset mid-operation discards all entries and restores priority.
// CONFIGURATION
//  QUEUE_BYPASS_EN defined: when count==0 and out_rdy_i=1, the winning payload is presented on
//    out_* combinationally and popped the same cycle without a FIFO write (0-cycle latency);
//    arbiter pointer still advances. out_vld_o = (count!=0) | (count==0 & |req_vld_i).
//    Consumer sees data from the FIFO whenever count!=0, preserving order.
//  Not defined: no combinational req->out path; minimum latency 1 cycle.
// STRUCTURE
//  - Shared commons package: clog2 helper constant function, FIFO pointer/count width localparams.
//  - One sub-module: round_robin_arbiter from commons (N). FIFO storage, pointers, payload
//    one-hot mux and index encoder live in this module.
// TESTING (N=4, W=8, DEPTH=4)
//  - Reset then idle: out_vld_o=0, out_data_o=0, req_rdy_o=0 for 10 cycles.
//  - All 4 sources valid (data 0x10..0x13), out_rdy_i=1 -> accepted order src 0,1,2,3,0,...;
//    out_src_o sequence identical, one cycle later.
//  - out_rdy_i=0, src 2 valid with 0xA0..0xA3 -> 4 pushes then req_rdy_o=0, out_vld_o=1;
//    set out_rdy_i=1 for one cycle -> pop occurs, no push that cycle, push resumes next cycle.
//  - Fill to 4, then src 1 and src 3 valid: grant goes to src 3 first (pointer after src 2),
//    then src 1; pointer does not advance during the full stall.
//  - Reset asserted with count=3 -> out_vld_o=0 same cycle; after release src 0 wins first.
//  - QUEUE_BYPASS_EN, empty, out_rdy_i=1, src 1 valid 0x55 -> out_vld_o=1, out_data_o=0x55,
//    req_rdy_o=4'b0010 same cycle, count stays 0.

Source files
------------

// File: rtl/rr_arb_queue_pkg.sv
// rr_arb_queue_pkg: shared defaults and width helper for the round-robin arbitrated queue.
package rr_arb_queue_pkg;
    localparam int N_DEF     = 4;
    localparam int W_DEF     = 32;
    localparam int DEPTH_DEF = 4;

    // Never returns 0, so the result can always size a vector.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/rr_arb_queue_if.sv
// rr_arb_queue_if: source request bus plus consumer drain bus of the arbitrated queue.
interface rr_arb_queue_if
    import rr_arb_queue_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
);
    logic [N-1:0]          req_vld_i;
    logic [N*W-1:0]        req_data_i;
    logic [N-1:0]          req_rdy_o;
    logic                  out_vld_o;
    logic [W-1:0]          out_data_o;
    logic [clog2(N)-1:0]   out_src_o;
    logic                  out_rdy_i;

    modport slave (
        input  req_vld_i, req_data_i, out_rdy_i,
        output req_rdy_o, out_vld_o, out_data_o, out_src_o
    );
    modport master (
        output req_vld_i, req_data_i, out_rdy_i,
        input  req_rdy_o, out_vld_o, out_data_o, out_src_o
    );
endinterface

// File: rtl/rr_arb_queue_arb.sv
// round_robin_arbiter: one-hot round-robin grant; priority moves past the winner only when it may go.
module round_robin_arbiter #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         req_can_go_i,
    output logic [N-1:0] gnt_o
);
    logic [N-1:0] mask_q, mask_d, req_m;

    // mask_q holds the sources above the last winner; empty mask wraps to source 0.
    always_comb begin
        req_m  = req_i & mask_q;
        gnt_o  = (|req_m) ? (req_m & (~req_m + N'(1))) : (req_i & (~req_i + N'(1)));
        mask_d = (req_can_go_i & |gnt_o) ? ~((gnt_o << 1) - N'(1)) : mask_q;
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) mask_q <= '1;
        else       mask_q <= mask_d;
endmodule

// File: rtl/rr_arb_queue.sv
// rr_arb_queue: N sources round-robin arbitrated into a DEPTH-entry FIFO drained by one consumer.
// Define QUEUE_BYPASS_EN for a zero-latency path from the winner to out_* while the FIFO is empty.
module rr_arb_queue
    import rr_arb_queue_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input logic           clk_i,
    input logic           rst_i,
    rr_arb_queue_if.slave bus
);
    localparam int SW = clog2(N);
    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [N-1:0]  gnt;
    logic          full, held, push, wr, pop;
    logic [W-1:0]  win_data;
    logic [SW-1:0] win_src;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [W-1:0]  data_mem_q [DEPTH];
    logic [SW-1:0] src_mem_q  [DEPTH];

    // Full is taken from the registered count only: a same-cycle pop never frees a slot for a push.
    assign full = count_q == DEPTH_C;
    assign held = count_q != '0;

    round_robin_arbiter #(.N(N)) u_arb (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (bus.req_vld_i),
        .req_can_go_i (~full),
        .gnt_o        (gnt)
    );

    always_comb begin
        win_data = '0;
        win_src  = '0;
        for (int k = 0; k < N; k++) begin
            win_data |= bus.req_data_i[k*W +: W] & {W{gnt[k]}};
            win_src  |= gnt[k] ? SW'(k) : '0;
        end
    end

    always_comb begin
        bus.req_rdy_o = gnt & {N{~full & ~rst_i}};
        push          = |bus.req_rdy_o;
`ifdef QUEUE_BYPASS_EN
        wr             = push & ~(~held & bus.out_rdy_i);
        bus.out_vld_o  = ~rst_i & (held | (|bus.req_vld_i));
        bus.out_data_o = ~bus.out_vld_o ? '0 : held ? data_mem_q[rd_ptr_q] : win_data;
        bus.out_src_o  = ~bus.out_vld_o ? '0 : held ? src_mem_q[rd_ptr_q] : win_src;
`else
        wr             = push;
        bus.out_vld_o  = held;
        bus.out_data_o = held ? data_mem_q[rd_ptr_q] : '0;
        bus.out_src_o  = held ? src_mem_q[rd_ptr_q] : '0;
`endif
        pop      = bus.out_vld_o & bus.out_rdy_i & held;
        count_d  = count_q + CW'(wr) - CW'(pop);
        wr_ptr_d = wr ? ((wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop ? ((rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end

    always_ff @(posedge clk_i)
        if (wr) begin
            data_mem_q[wr_ptr_q] <= win_data;
            src_mem_q[wr_ptr_q]  <= win_src;
        end
endmodule

// File: tb/tb_rr_arb_queue.sv
// tb_rr_arb_queue: directed stimulus checked every cycle against a queue-based model plus literal pins.
module tb_rr_arb_queue;
    localparam int N = 4, W = 8, DEPTH = 4;
`ifdef QUEUE_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    rr_arb_queue_if #(.N(N), .W(W)) bus ();
    rr_arb_queue #(.N(N), .W(W), .DEPTH(DEPTH)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] d; int s; } ent_t;
    ent_t q[$];
    int   last = N - 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the FIFO is a queue, the arbiter is "first valid source after the last winner".
    always @(negedge clk) begin : model
        int           win;
        logic [N-1:0] e_rdy;
        logic         e_vld, byp;
        logic [W-1:0] e_data;
        int           e_src;
        if (rst) begin
            check("rst_rdy", 32'(bus.req_rdy_o), 32'd0);
            check("rst_vld", 32'(bus.out_vld_o), 32'd0);
            check("rst_data", 32'(bus.out_data_o), 32'd0);
            check("rst_src", 32'(bus.out_src_o), 32'd0);
            q.delete();
            last = N - 1;
        end else begin
            win = -1;
            for (int i = 1; i <= N; i++)
                if (win < 0 && bus.req_vld_i[(last + i) % N]) win = (last + i) % N;
            e_rdy = '0;
            if (q.size() < DEPTH && win >= 0) e_rdy[win] = 1'b1;
`ifdef QUEUE_BYPASS_EN
            byp   = q.size() == 0 && bus.out_rdy_i;
            e_vld = q.size() != 0 || win >= 0;
`else
            byp   = 1'b0;
            e_vld = q.size() != 0;
`endif
            e_data = q.size() != 0 ? q[0].d : (e_vld ? bus.req_data_i[win*W +: W] : '0);
            e_src  = q.size() != 0 ? q[0].s : (e_vld ? win : 0);
            check("m_rdy", 32'(bus.req_rdy_o), 32'(e_rdy));
            check("m_vld", 32'(bus.out_vld_o), 32'(e_vld));
            check("m_data", 32'(bus.out_data_o), 32'(e_data));
            check("m_src", 32'(bus.out_src_o), 32'(e_src));
            if (e_vld && bus.out_rdy_i && q.size() != 0) void'(q.pop_front());
            if (e_rdy != '0) begin
                last = win;
                if (!byp) q.push_back('{d: bus.req_data_i[win*W +: W], s: win});
            end
        end
    end

    task automatic cyc(input logic [N-1:0] v, input logic r, input logic [N*W-1:0] d);
        @(posedge clk);
        #1;
        bus.req_vld_i  = v;
        bus.out_rdy_i  = r;
        bus.req_data_i = d;
        #1;
    endtask

    localparam logic [N*W-1:0] D_BASE = {8'h13, 8'h12, 8'h11, 8'h10};
    localparam logic [N*W-1:0] D_B    = {8'hB3, 8'h00, 8'hB1, 8'h00};

    initial begin
        bus.req_vld_i  = '0;
        bus.out_rdy_i  = 1'b0;
        bus.req_data_i = D_BASE;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) cyc('0, 1'b0, D_BASE);
        check("idle_vld", 32'(bus.out_vld_o), 32'd0);
        check("idle_rdy", 32'(bus.req_rdy_o), 32'd0);
        check("idle_data", 32'(bus.out_data_o), 32'd0);

        for (int i = 0; i < 6; i++) begin
            cyc(4'hF, 1'b1, D_BASE);
            check("rr_rdy", 32'(bus.req_rdy_o), 32'd1 << (i % 4));
            if (i >= LAT) begin
                check("rr_src", 32'(bus.out_src_o), 32'((i - LAT) % 4));
                check("rr_data", 32'(bus.out_data_o), 32'(8'h10 + (i - LAT) % 4));
            end
        end
        cyc('0, 1'b1, D_BASE);
        check("drain_vld", 32'(bus.out_vld_o), 32'(LAT));
        check("drain_src", 32'(bus.out_src_o), 32'(LAT));

        for (int i = 0; i < 4; i++) begin
            cyc(4'b0100, 1'b0, {8'h13, 8'(8'hA0 + i), 8'h11, 8'h10});
            check("fill_rdy", 32'(bus.req_rdy_o), 32'h4);
        end
        cyc(4'b0100, 1'b0, {8'h13, 8'hA4, 8'h11, 8'h10});
        check("full_rdy", 32'(bus.req_rdy_o), 32'h0);
        check("full_vld", 32'(bus.out_vld_o), 32'h1);
        check("full_data", 32'(bus.out_data_o), 32'hA0);
        check("full_src", 32'(bus.out_src_o), 32'h2);
        cyc(4'b0100, 1'b1, {8'h13, 8'hA4, 8'h11, 8'h10});
        check("popfull_rdy", 32'(bus.req_rdy_o), 32'h0);
        cyc(4'b0100, 1'b0, {8'h13, 8'hA4, 8'h11, 8'h10});
        check("resume_rdy", 32'(bus.req_rdy_o), 32'h4);
        check("resume_data", 32'(bus.out_data_o), 32'hA1);

        repeat (3) begin
            cyc(4'b1010, 1'b0, D_B);
            check("stall_rdy", 32'(bus.req_rdy_o), 32'h0);
        end
        cyc(4'b1010, 1'b1, D_B);
        check("stallpop_rdy", 32'(bus.req_rdy_o), 32'h0);
        cyc(4'b1010, 1'b0, D_B);
        check("after2_rdy", 32'(bus.req_rdy_o), 32'h8);
        cyc(4'b1010, 1'b1, D_B);
        cyc(4'b1010, 1'b0, D_B);
        check("after3_rdy", 32'(bus.req_rdy_o), 32'h2);

        cyc('0, 1'b1, D_B);
        check("pre_rst_data", 32'(bus.out_data_o), 32'hA3);
        @(posedge clk);
        #1 rst = 1'b1;
        bus.req_vld_i = '0;
        #1;
        check("midrst_vld", 32'(bus.out_vld_o), 32'h0);
        check("midrst_data", 32'(bus.out_data_o), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(4'hF, 1'b1, D_BASE);
        check("postrst_rdy", 32'(bus.req_rdy_o), 32'h1);
        cyc(4'hF, 1'b1, D_BASE);
        check("postrst_src", 32'(bus.out_src_o), 32'(1 - LAT));
        check("postrst_data", 32'(bus.out_data_o), 32'(8'h11 - LAT));
        cyc('0, 1'b1, D_BASE);
        check("postrst_drain", 32'(bus.out_vld_o), 32'(LAT));

        cyc(4'b0010, 1'b1, {8'h00, 8'h00, 8'h55, 8'h00});
        check("one_rdy", 32'(bus.req_rdy_o), 32'h2);
`ifdef QUEUE_BYPASS_EN
        check("byp_vld", 32'(bus.out_vld_o), 32'h1);
        check("byp_data", 32'(bus.out_data_o), 32'h55);
        cyc('0, 1'b1, D_BASE);
        check("byp_after_vld", 32'(bus.out_vld_o), 32'h0);
`else
        check("lat_vld", 32'(bus.out_vld_o), 32'h0);
        cyc('0, 1'b1, D_BASE);
        check("lat_after_vld", 32'(bus.out_vld_o), 32'h1);
        check("lat_after_data", 32'(bus.out_data_o), 32'h55);
        check("lat_after_src", 32'(bus.out_src_o), 32'h1);
`endif
        repeat (3) cyc('0, 1'b1, D_BASE);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
